icap_warmboot_sequencer: RTL

Controller for the Xilinx 7-series ICAPE2 primitive that issues the IPROG warm-boot command stream, reconfiguring the FPGA from a selected SPI flash address. It sits beside the DFU core in the bootloader top level. It accepts a boot request and applies a programmable hold-off that the DFU core can cancel through `inhibit`. Once the hold-off expires, it sequences the fixed 8-word ICAP command stream, one word per clock.

---
 rtl/icap_warmboot_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/icap_warmboot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : icap_warmboot_sequencer
//  Description : Drives the ICAPE2 IPROG warm-boot command stream after a
//                cancellable hold-off, rebooting from a selected flash address.
//  Revision    : 1.0 - initial release
// ============================================================================
module icap_warmboot_sequencer #(
    parameter logic [31:0] DEFAULT_ADDR   = 32'h0010_0000,
    parameter int          HOLDOFF_CYCLES = 65535,
    parameter bit          BITSWAP        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_req,
    input  logic [31:0] boot_addr,
    input  logic        boot_addr_valid,
    input  logic        inhibit,
    output logic        busy,
    output logic        done,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_data
);

    localparam int c_CNT_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(HOLDOFF_CYCLES);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_HOLDOFF = 2'd1;
    localparam logic [1:0] c_S_SEND    = 2'd2;
    localparam logic [1:0] c_S_DONE    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [31:0]        r_addr;
    logic               w_accept;
    logic [31:0]        w_word;
    logic [31:0]        w_word_out;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_csib_next;
    logic               w_rdwrb_next;
    logic [31:0]        w_data_next;

    assign w_accept = boot_req && !inhibit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; inhibit wins over hold-off expiry
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (HOLDOFF_CYCLES == 0) ? c_S_SEND : c_S_HOLDOFF;
                end
            end
            c_S_HOLDOFF: begin
                if (inhibit) begin
                    w_state_next = c_S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = c_S_SEND;
                end
            end
            c_S_SEND: begin
                if (r_idx == 3'd7) begin
                    w_state_next = c_S_DONE;
                end
            end
            default: w_state_next = c_S_DONE;
        endcase
    end

    // Hold-off counter, word index and latched boot address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_addr <= DEFAULT_ADDR;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_cnt  <= c_CNT_LOAD;
                        r_addr <= boot_addr_valid ? boot_addr : DEFAULT_ADDR;
                    end
                end
                c_S_HOLDOFF: begin
                    if (inhibit) begin
                        r_cnt <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_SEND: r_idx <= r_idx + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_idx)
            3'd0:    w_word = 32'hFFFF_FFFF;
            3'd1:    w_word = 32'hAA99_5566;
            3'd2:    w_word = 32'h2000_0000;
            3'd3:    w_word = 32'h3002_0001;
            3'd4:    w_word = r_addr;
            3'd5:    w_word = 32'h3000_8001;
            3'd6:    w_word = 32'h0000_000F;
            default: w_word = 32'h2000_0000;
        endcase
    end

    // ICAPE2 expects each byte bit-reversed relative to the bitstream order
    generate
        if (BITSWAP) begin : g_swap
            for (genvar k = 0; k < 4; k++) begin : g_byte
                for (genvar j = 0; j < 8; j++) begin : g_bit
                    assign w_word_out[8*k+j] = w_word[8*k+(7-j)];
                end
            end
        end else begin : g_noswap
            assign w_word_out = w_word;
        end
    endgenerate

    // Output decode, registered below so every port comes from a flop
    always_comb begin
        w_busy_next  = (w_state_next != c_S_IDLE);
        w_done_next  = (r_state == c_S_DONE);
        w_csib_next  = (r_state != c_S_SEND);
        w_rdwrb_next = (r_state != c_S_SEND);
        w_data_next  = (r_state == c_S_SEND) ? w_word_out : 32'hFFFF_FFFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            icap_data  <= 32'hFFFF_FFFF;
        end else begin
            busy       <= w_busy_next;
            done       <= w_done_next;
            icap_csib  <= w_csib_next;
            icap_rdwrb <= w_rdwrb_next;
            icap_data  <= w_data_next;
        end
    end

endmodule
`default_nettype wire
